cnn_conv_stream_sequencer: RTL and testbench

- Controller that runs one dilated 3x3 convolution engine (ASPP-branch style) end to end.
- On a start pulse it resets the engine, then fetches pixels and weights from two on-chip read memories. It streams them into the engine as the engine expects: both streams start on the same cycle, pixel-major, channel by channel.
- It captures every engine output into an output buffer and reports done, or error on a stall timeout.
- Sits between the layer-level scheduler and the feature-map/weight memories of the conv engine.

---
 rtl/cnn_seq_pkg.sv | 38 +++
 rtl/cnn_seq_out_capture.sv | 49 ++++
 rtl/cnn_conv_stream_sequencer.sv | 132 +++++++++++++
 tb/tb_cnn_conv_stream_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// Shared types and size helpers for the dilated-conv stream sequencer.
// Derived sizes are functions so the top and the capture stage agree on widths.
package cnn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    function automatic int pixel_num(input int ch_in, input int width, input int height);
        return ch_in * width * height;
    endfunction

    function automatic int weight_num(input int ch_in, input int ch_out, input int kernel);
        return ch_in * ch_out * kernel * kernel;
    endfunction

    function automatic int out_num(input int width, input int height, input int ch_out);
        return width * height * ch_out;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Address width for n words; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cnn_seq_out_capture.sv
// Output capture: counts engine results, drops anything past OUT_NUM and
// registers one buffer write per accepted result.
module cnn_seq_out_capture
    import cnn_seq_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int OUT_NUM    = 256,
    localparam int OUT_AW     = addr_w(OUT_NUM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  conv_valid_out,
    input  logic [DATA_WIDTH-1:0] conv_pxl_out,
    output logic                  full,
    output logic                  out_wr_en,
    output logic [OUT_AW-1:0]     out_wr_addr,
    output logic [DATA_WIDTH-1:0] out_wr_data
);

    localparam int              CNT_W    = cnt_w(OUT_NUM);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_NUM);

    logic [CNT_W-1:0] out_cnt;

    // Full from the cycle of the last write, so done always lands a cycle later.
    assign full = (out_cnt == CNT_FULL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_cnt     <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
        end else begin
            out_wr_en <= 1'b0;
            if (clear) begin
                out_cnt <= '0;
            end else if (enable && conv_valid_out && !full) begin
                out_wr_en   <= 1'b1;
                out_wr_addr <= OUT_AW'(out_cnt);
                out_wr_data <= conv_pxl_out;
                out_cnt     <= out_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cnn_conv_stream_sequencer.sv
// Runs one dilated 3x3 conv engine: reset it, stream pixels and weights from
// two 1-cycle-latency memories, capture its results, flag a drain stall.
module cnn_conv_stream_sequencer
    import cnn_seq_pkg::*;
#(
    parameter  int DATA_WIDTH      = 32,
    parameter  int IMAGE_WIDTH     = 16,
    parameter  int IMAGE_HEIGHT    = 16,
    parameter  int CHANNEL_NUM_IN  = 512,
    parameter  int CHANNEL_NUM_OUT = 1,
    parameter  int KERNEL          = 3,
    parameter  int TIMEOUT         = 65535,
    localparam int PIXEL_NUM       = pixel_num(CHANNEL_NUM_IN, IMAGE_WIDTH, IMAGE_HEIGHT),
    localparam int WEIGHT_NUM      = weight_num(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL),
    localparam int OUT_NUM         = out_num(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_OUT),
    localparam int PXL_AW          = addr_w(PIXEL_NUM),
    localparam int WGT_AW          = addr_w(WEIGHT_NUM),
    localparam int OUT_AW          = addr_w(OUT_NUM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [PXL_AW-1:0]     pxl_rd_addr,
    input  logic [DATA_WIDTH-1:0] pxl_rd_data,
    output logic [WGT_AW-1:0]     wgt_rd_addr,
    input  logic [DATA_WIDTH-1:0] wgt_rd_data,
    output logic                  conv_rst,
    output logic                  conv_valid_in,
    output logic [DATA_WIDTH-1:0] conv_pxl_in,
    output logic                  conv_valid_weight_in,
    output logic [DATA_WIDTH-1:0] conv_weight_in,
    input  logic                  conv_valid_out,
    input  logic [DATA_WIDTH-1:0] conv_pxl_out,
    output logic                  out_wr_en,
    output logic [OUT_AW-1:0]     out_wr_addr,
    output logic [DATA_WIDTH-1:0] out_wr_data
);

    localparam int STREAM_LEN = max_int(PIXEL_NUM, WEIGHT_NUM);
    localparam int IDX_W      = addr_w(STREAM_LEN);
    localparam int STALL_W    = cnt_w(TIMEOUT);

    localparam logic [IDX_W-1:0]   STREAM_LAST = IDX_W'(STREAM_LEN - 1);
    localparam logic [IDX_W-1:0]   PXL_LAST    = IDX_W'(PIXEL_NUM - 1);
    localparam logic [IDX_W-1:0]   WGT_LAST    = IDX_W'(WEIGHT_NUM - 1);
    localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(TIMEOUT - 1);

    seq_state_t          state, state_next;
    logic [IDX_W-1:0]    idx;
    logic [STALL_W-1:0]  stall_cnt;
    logic                accept_start, stream_last, timeout_hit, out_full;
    logic                pxl_live, wgt_live;

    assign accept_start = (state == IDLE) && start;
    assign stream_last  = (idx == STREAM_LAST);
    assign timeout_hit  = !conv_valid_out && (stall_cnt == STALL_LAST);
    assign pxl_live     = (idx <= PXL_LAST);
    assign wgt_live     = (idx <= WGT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: next state defaults to the current state before the case, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (stream_last) state_next = DRAIN;
            DRAIN:   if (out_full || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx                  <= '0;
            stall_cnt            <= '0;
            error                <= 1'b0;
            conv_valid_in        <= 1'b0;
            conv_valid_weight_in <= 1'b0;
        end else begin
            // Valids trail the address by the memory's one-cycle read latency.
            conv_valid_in        <= (state == STREAM) && pxl_live;
            conv_valid_weight_in <= (state == STREAM) && wgt_live;
            if (accept_start) begin
                idx       <= '0;
                stall_cnt <= '0;
                error     <= 1'b0;
            end else begin
                if (state == STREAM && !stream_last) idx <= idx + IDX_W'(1);
                if (state == DRAIN) begin
                    stall_cnt <= conv_valid_out ? '0 : stall_cnt + STALL_W'(1);
                    if (!out_full && timeout_hit) error <= 1'b1;
                end
            end
        end
    end

    assign busy     = (state == STREAM) || (state == DRAIN);
    assign done     = (state == DONE);
    assign conv_rst = (state == IDLE);

    // The shorter stream parks on its last address while the longer one finishes.
    assign pxl_rd_addr    = (state == STREAM) ? PXL_AW'(pxl_live ? idx : PXL_LAST) : '0;
    assign wgt_rd_addr    = (state == STREAM) ? WGT_AW'(wgt_live ? idx : WGT_LAST) : '0;
    assign conv_pxl_in    = conv_valid_in        ? pxl_rd_data : '0;
    assign conv_weight_in = conv_valid_weight_in ? wgt_rd_data : '0;

    cnn_seq_out_capture #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_NUM    (OUT_NUM)
    ) u_out_capture (
        .clk            (clk),
        .reset          (reset),
        .clear          (accept_start),
        .enable         (busy),
        .conv_valid_out (conv_valid_out),
        .conv_pxl_out   (conv_pxl_out),
        .full           (out_full),
        .out_wr_en      (out_wr_en),
        .out_wr_addr    (out_wr_addr),
        .out_wr_data    (out_wr_data)
    );

endmodule

// File: tb/tb_cnn_conv_stream_sequencer.sv
// Self-checking bench: job table with a timing model of the stream/drain rules,
// plus hand sequences for mid-stream reset and a weight-dominated geometry.
module tb_cnn_conv_stream_sequencer;

    localparam int DW   = 32;
    localparam int PN_A = 32, WN_A = 18, ON_A = 16, SL_A = 32, TO_A = 8;
    localparam int PN_B = 4,  WN_B = 36, ON_B = 16, SL_B = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Instance A: 4x4 image, 2 in channels, 1 out channel, TIMEOUT 8
    logic          start_a, busy_a, done_a, error_a, conv_rst_a;
    logic [4:0]    pxl_rd_addr_a, wgt_rd_addr_a;
    logic [DW-1:0] pxl_rd_data_a, wgt_rd_data_a, conv_pxl_in_a, conv_weight_in_a;
    logic          conv_valid_in_a, conv_valid_weight_in_a, conv_valid_out_a, out_wr_en_a;
    logic [DW-1:0] conv_pxl_out_a, out_wr_data_a;
    logic [3:0]    out_wr_addr_a;

    // Instance B: 2x2 image, 1 in channel, 4 out channels
    logic          start_b, busy_b, done_b, error_b, conv_rst_b;
    logic [1:0]    pxl_rd_addr_b;
    logic [5:0]    wgt_rd_addr_b;
    logic [DW-1:0] pxl_rd_data_b, wgt_rd_data_b, conv_pxl_in_b, conv_weight_in_b;
    logic          conv_valid_in_b, conv_valid_weight_in_b, conv_valid_out_b, out_wr_en_b;
    logic [DW-1:0] conv_pxl_out_b, out_wr_data_b;
    logic [3:0]    out_wr_addr_b;

    logic [DW-1:0] pxl_mem_a [PN_A];
    logic [DW-1:0] wgt_mem_a [WN_A];
    logic [DW-1:0] pxl_mem_b [PN_B];
    logic [DW-1:0] wgt_mem_b [WN_B];

    cnn_conv_stream_sequencer #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(2),
        .CHANNEL_NUM_OUT(1), .KERNEL(3), .TIMEOUT(TO_A)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .error(error_a),
        .pxl_rd_addr(pxl_rd_addr_a), .pxl_rd_data(pxl_rd_data_a),
        .wgt_rd_addr(wgt_rd_addr_a), .wgt_rd_data(wgt_rd_data_a),
        .conv_rst(conv_rst_a), .conv_valid_in(conv_valid_in_a), .conv_pxl_in(conv_pxl_in_a),
        .conv_valid_weight_in(conv_valid_weight_in_a), .conv_weight_in(conv_weight_in_a),
        .conv_valid_out(conv_valid_out_a), .conv_pxl_out(conv_pxl_out_a),
        .out_wr_en(out_wr_en_a), .out_wr_addr(out_wr_addr_a), .out_wr_data(out_wr_data_a)
    );

    cnn_conv_stream_sequencer #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNEL_NUM_IN(1),
        .CHANNEL_NUM_OUT(4), .KERNEL(3), .TIMEOUT(TO_A)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .error(error_b),
        .pxl_rd_addr(pxl_rd_addr_b), .pxl_rd_data(pxl_rd_data_b),
        .wgt_rd_addr(wgt_rd_addr_b), .wgt_rd_data(wgt_rd_data_b),
        .conv_rst(conv_rst_b), .conv_valid_in(conv_valid_in_b), .conv_pxl_in(conv_pxl_in_b),
        .conv_valid_weight_in(conv_valid_weight_in_b), .conv_weight_in(conv_weight_in_b),
        .conv_valid_out(conv_valid_out_b), .conv_pxl_out(conv_pxl_out_b),
        .out_wr_en(out_wr_en_b), .out_wr_addr(out_wr_addr_b), .out_wr_data(out_wr_data_b)
    );

    // Synchronous-read memories with one cycle of latency
    always @(posedge clk) begin
        pxl_rd_data_a <= pxl_mem_a[pxl_rd_addr_a];
        wgt_rd_data_a <= wgt_mem_a[wgt_rd_addr_a];
        pxl_rd_data_b <= pxl_mem_b[pxl_rd_addr_b];
        wgt_rd_data_b <= wgt_mem_b[wgt_rd_addr_b];
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit prev_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    typedef struct {
        int n_emit;      // engine results emitted
        int offset;      // cycle of first result, counted from the start cycle
        int gap;         // cycles between results
        bit poke;        // extra start pulses during STREAM and DRAIN
        int exp_writes;  // buffer writes expected
        bit exp_err;     // timeout expected
    } job_t;

    // One job on instance A: cycle t=0 is the start cycle, t=1 the first STREAM cycle.
    task automatic run_job_a(input job_t j, input string tag);
        int em_time[$];
        logic [DW-1:0] em_data[$];
        int done_t, t_limit, ei, wr, done_cnt, done_seen, last_wr_t;
        int addr_bad, pxl_bad, wgt_bad, ctl_bad, wr_bad;
        bit exp_pv, exp_wv;
        for (int i = 0; i < j.n_emit; i++) begin
            em_time.push_back(j.offset + i * j.gap);
            em_data.push_back($urandom);
        end
        if (j.exp_err)
            done_t = imax(em_time[j.n_emit - 1] + 1, SL_A + 1) + TO_A;
        else
            done_t = imax(SL_A + 1, em_time[j.exp_writes - 1] + 1) + 1;
        t_limit = imax(done_t, em_time[j.n_emit - 1]) + 4;
        {ei, wr, done_cnt, addr_bad, pxl_bad, wgt_bad, ctl_bad, wr_bad} = '0;
        done_seen = -1;
        last_wr_t = -1;

        @(negedge clk);
        check({tag, "_idle_before"}, {61'd0, busy_a, done_a, conv_rst_a}, 64'd1);
        check({tag, "_prev_err"}, {63'd0, error_a}, {63'd0, prev_err});
        start_a = 1'b1;
        for (int t = 1; t <= t_limit; t++) begin
            @(negedge clk);
            start_a = j.poke && (t == 10 || t == SL_A + 2);
            if (t >= 1 && t <= SL_A) begin
                if (pxl_rd_addr_a !== 5'(imin(t - 1, PN_A - 1)) ||
                    wgt_rd_addr_a !== 5'(imin(t - 1, WN_A - 1))) addr_bad++;
            end
            exp_pv = (t >= 2 && t <= PN_A + 1);
            exp_wv = (t >= 2 && t <= WN_A + 1);
            if (conv_valid_in_a !== exp_pv) pxl_bad++;
            else if (exp_pv && conv_pxl_in_a !== pxl_mem_a[t - 2]) pxl_bad++;
            if (conv_valid_weight_in_a !== exp_wv) wgt_bad++;
            else if (exp_wv && conv_weight_in_a !== wgt_mem_a[t - 2]) wgt_bad++;
            if ({busy_a, done_a, conv_rst_a, error_a} !==
                {t < done_t, t == done_t, t > done_t, j.exp_err && t >= done_t}) ctl_bad++;
            if (done_a) begin
                done_cnt++;
                if (done_seen < 0) done_seen = t;
                if (out_wr_en_a) wr_bad++;
            end
            if (out_wr_en_a) begin
                if (wr >= j.n_emit) wr_bad++;
                else if (out_wr_addr_a !== 4'(wr) || out_wr_data_a !== em_data[wr] ||
                         t != em_time[wr] + 1) wr_bad++;
                wr++;
                last_wr_t = t;
            end
            conv_pxl_out_a = $urandom;
            conv_valid_out_a = (ei < j.n_emit) && (em_time[ei] == t);
            if (conv_valid_out_a) begin
                conv_pxl_out_a = em_data[ei];
                ei++;
            end
        end
        conv_valid_out_a = 1'b0;
        start_a = 1'b0;

        check({tag, "_addr_errs"}, 64'(addr_bad), 64'd0);
        check({tag, "_pxl_stream_errs"}, 64'(pxl_bad), 64'd0);
        check({tag, "_wgt_stream_errs"}, 64'(wgt_bad), 64'd0);
        check({tag, "_ctl_errs"}, 64'(ctl_bad), 64'd0);
        check({tag, "_write_errs"}, 64'(wr_bad), 64'd0);
        check({tag, "_write_count"}, 64'(wr), 64'(j.exp_writes));
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_cycle"}, 64'(done_seen), 64'(done_t));
        check({tag, "_done_after_write"}, 64'(last_wr_t < done_seen), 64'd1);
        check({tag, "_error_end"}, {63'd0, error_a}, {63'd0, j.exp_err});
        prev_err = j.exp_err;
    endtask

    initial begin
        job_t jobs[6];
        int done_cnt, pv_cnt, pv_first, wv_cnt, wv_first, wv_last, wr_b, done_b_cnt;
        logic [1:0] held_pxl;
        logic [5:0] last_wgt;

        jobs[0] = '{n_emit: 16, offset: 2,  gap: 1, poke: 1'b0, exp_writes: 16, exp_err: 1'b0};
        jobs[1] = '{n_emit: 16, offset: 4,  gap: 2, poke: 1'b1, exp_writes: 16, exp_err: 1'b0};
        jobs[2] = '{n_emit: 20, offset: 2,  gap: 1, poke: 1'b0, exp_writes: 16, exp_err: 1'b0};
        jobs[3] = '{n_emit: 20, offset: 25, gap: 1, poke: 1'b0, exp_writes: 16, exp_err: 1'b0};
        jobs[4] = '{n_emit: 10, offset: 30, gap: 1, poke: 1'b0, exp_writes: 10, exp_err: 1'b1};
        jobs[5] = '{n_emit: 16, offset: 3,  gap: 3, poke: 1'b0, exp_writes: 16, exp_err: 1'b0};

        foreach (pxl_mem_a[i]) pxl_mem_a[i] = $urandom;
        foreach (wgt_mem_a[i]) wgt_mem_a[i] = $urandom;
        foreach (pxl_mem_b[i]) pxl_mem_b[i] = $urandom;
        foreach (wgt_mem_b[i]) wgt_mem_b[i] = $urandom;

        reset = 1'b0;
        {start_a, conv_valid_out_a, start_b, conv_valid_out_b} = '0;
        conv_pxl_out_a = '0;
        conv_pxl_out_b = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl_a", {57'd0, busy_a, done_a, error_a, conv_rst_a, conv_valid_in_a,
              conv_valid_weight_in_a, out_wr_en_a}, 64'b0001000);
        check("rst_addr_a", {54'd0, pxl_rd_addr_a, wgt_rd_addr_a}, 64'd0);
        check("rst_data_a", {conv_pxl_in_a, out_wr_data_a}, 64'd0);
        check("rst_ctl_b", {57'd0, busy_b, done_b, error_b, conv_rst_b, conv_valid_in_b,
              conv_valid_weight_in_b, out_wr_en_b}, 64'b0001000);
        reset = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_job_a(jobs[k], $sformatf("job%0d", k));

        // Reset while STREAM is at idx 7: immediate abort, no done.
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        check("midrst_addr_before", 64'(pxl_rd_addr_a), 64'd7);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ctl", {58'd0, busy_a, done_a, conv_rst_a, conv_valid_in_a,
              conv_valid_weight_in_a, out_wr_en_a}, 64'b001000);
        reset = 1'b1;
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_a) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        prev_err = 1'b0;
        run_job_a(jobs[0], "replay");

        // Weight stream longer than pixel stream on instance B.
        {pv_cnt, wv_cnt, wr_b, done_b_cnt} = '0;
        {pv_first, wv_first, wv_last} = {-1, -1, -1};
        held_pxl = '1;
        last_wgt = '0;
        @(negedge clk);
        start_b = 1'b1;
        for (int t = 1; t <= 45; t++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (conv_valid_in_b) begin
                pv_cnt++;
                if (pv_first < 0) pv_first = t;
            end
            if (conv_valid_weight_in_b) begin
                wv_cnt++;
                if (wv_first < 0) wv_first = t;
                wv_last = t;
            end
            if (t == 6) held_pxl = pxl_rd_addr_b;
            if (t == SL_B) last_wgt = wgt_rd_addr_b;
            if (out_wr_en_b) wr_b++;
            if (done_b) done_b_cnt++;
            conv_valid_out_b = (t >= 10 && t < 10 + ON_B);
            conv_pxl_out_b = $urandom;
        end
        conv_valid_out_b = 1'b0;
        check("b_pxl_valid_count", 64'(pv_cnt), 64'(PN_B));
        check("b_pxl_valid_first", 64'(pv_first), 64'd2);
        check("b_wgt_valid_count", 64'(wv_cnt), 64'(WN_B));
        check("b_wgt_valid_first", 64'(wv_first), 64'd2);
        check("b_wgt_valid_last", 64'(wv_last), 64'(WN_B + 1));
        check("b_pxl_addr_held", 64'(held_pxl), 64'(PN_B - 1));
        check("b_wgt_addr_last", 64'(last_wgt), 64'(SL_B - 1));
        check("b_write_count", 64'(wr_b), 64'(ON_B));
        check("b_done_count", 64'(done_b_cnt), 64'd1);
        check("b_error", {63'd0, error_b}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
